axil_regbank: RTL and testbench
===============================

AXIL_REGBANK -- requirements
Module: axil_regbank

Interface
REQ-001 Parameter ID_VALUE, default 32'h4B32_5D01, constant returned by the ID register.
REQ-002 Clk  input  1  single clock; all logic rising-edge.
REQ-003 reset_rtl_0  input  1  reset, asynchronous, active-high.
REQ-004 S_AXI_awaddr  input  32 / S_AXI_awprot  input  3 (ignored) / S_AXI_awvalid  input  1 / S_AXI_awready  output  1.
REQ-005 S_AXI_wdata  input  32 / S_AXI_wstrb  input  4 / S_AXI_wvalid  input  1 / S_AXI_wready  output  1.
REQ-006 S_AXI_bresp  output  2 / S_AXI_bvalid  output  1 / S_AXI_bready  input  1.
REQ-007 S_AXI_araddr  input  32 / S_AXI_arprot  input  3 (ignored) / S_AXI_arvalid  input  1 / S_AXI_arready  output  1.
REQ-008 S_AXI_rdata  output  32 / S_AXI_rresp  output  2 / S_AXI_rvalid  output  1 / S_AXI_rready  input  1.
REQ-009 ctrl_out  output  8  CTRL register bits [7:0].
REQ-010 status_in  input  8  per-bit set pulses into STATUS.

Function
REQ-011 The block SHALL be an AXI4-Lite slave on the microblaze M01_AXI_0 port; decode uses addr[11:2]; addr[31:12] and addr[1:0] are ignored.
REQ-012 Map: 0x00 ID (RO), 0x04 SCRATCH (RW), 0x08 CTRL (RW, bits [7:0], upper bits read 0), 0x0C STATUS (W1C, bits [7:0]), 0x10 CYCLE_LO (RO), 0x14 CYCLE_HI (RO snapshot).
REQ-013 Offsets 0x18-0xFFC SHALL respond SLVERR (2'b10), reads return 0, writes have no effect; all mapped offsets respond OKAY, including writes to RO registers (ignored).
REQ-014 Write channel: AW and W are accepted independently; awready=1 while no address is held and bvalid=0; wready=1 while no data is held and bvalid=0.
REQ-015 Once both address and data are held, the register update SHALL occur on the next edge and bvalid SHALL rise on that same edge; held AW/W flags clear on that edge.
REQ-016 If AW and W handshake in the same cycle, bvalid SHALL assert exactly one cycle later.
REQ-017 bvalid/bresp SHALL remain stable until bready=1; awready/wready stay 0 while bvalid=1.
REQ-018 RW writes honour wstrb per byte; STATUS write clears bits where wdata=1 within enabled byte 0.
REQ-019 Read channel: arready=1 while rvalid=0; on AR handshake rdata/rresp SHALL be registered and rvalid asserted the next cycle, held stable until rready=1.
REQ-020 The next AR handshake may occur the cycle after rvalid&rready (no back-to-back accept while rvalid=1).
REQ-021 Read and write channels SHALL operate concurrently and independently.
REQ-022 64-bit cycle counter increments every Clk, wraps 2^64-1 -> 0.
REQ-023 A read of CYCLE_LO returns counter[31:0] and in the same edge captures counter[63:32] into the CYCLE_HI snapshot; CYCLE_HI reads return the snapshot.
REQ-024 STATUS bit i SHALL set on any cycle status_in[i]=1; if set and W1C-clear coincide, set wins.
REQ-025 ctrl_out SHALL equal CTRL[7:0] combinationally from the register (no extra latency beyond the write edge).

Reset
REQ-026 While reset_rtl_0=1: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; SCRATCH, CTRL, STATUS, counter, snapshot = 0; held flags cleared.
REQ-027 Reset mid-transaction SHALL abort it silently; the first cycle after release, awready=wready=arready=1.

Verification
REQ-028 Write 0x04=0xDEADBEEF, strb 4'hF, AW+W same cycle -> bvalid one cycle later, bresp=0; read 0x04 -> rdata 0xDEADBEEF, rresp=0, rvalid one cycle after AR.
REQ-029 W three cycles before AW to 0x08 data 0x1A5, strb 4'h1 -> ctrl_out=0xA5; read 0x08 -> 0x000000A5; bready held 0 for 4 cycles -> bvalid stays 1, awready=0.
REQ-030 Pulse status_in=0x81 -> STATUS reads 0x81; write 0x0C=0x01 -> reads 0x80; write 0x80 while status_in[7]=1 same edge -> bit 7 remains 1.
REQ-031 Read 0x18 and write 0x100 -> rresp=bresp=2'b10, rdata=0; read 0x00 -> ID_VALUE, OKAY.
REQ-032 Force counter to 0xFFFFFFFF_FFFFFFFE, read 0x10 then 0x14 -> consistent LO/HI pair; after wrap counter=0.
REQ-033 Assert reset_rtl_0 with rvalid=1 and AW held -> rvalid=0 immediately, registers 0, all readys 1 after release.

Source files
------------

// File: rtl/axil_regbank_if.sv
// rtl/axil_regbank_if.sv - AXI4-Lite bus bundle between the processor port and the register bank

interface axil_regbank_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_regbank.sv
// rtl/axil_regbank.sv - AXI4-Lite register bank with ID, scratch, control, status and cycle counter

module axil_regbank #(
  parameter logic [31:0] ID_VALUE = 32'h4B32_5D01
) (
  input  logic          Clk,
  input  logic          reset_rtl_0,
  axil_regbank_if.slave S_AXI,
  output logic [7:0]    ctrl_out,
  input  logic [7:0]    status_in
);

  localparam logic [9:0] IDX_ID       = 10'd0;
  localparam logic [9:0] IDX_SCRATCH  = 10'd1;
  localparam logic [9:0] IDX_CTRL     = 10'd2;
  localparam logic [9:0] IDX_STATUS   = 10'd3;
  localparam logic [9:0] IDX_CYCLE_LO = 10'd4;
  localparam logic [9:0] IDX_CYCLE_HI = 10'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic        aw_held;
  logic        w_held;
  logic [9:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        do_write;
  logic [1:0]  wr_resp;
  logic [9:0]  ar_idx;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [31:0] scratch_q;
  logic [7:0]  ctrl_q;
  logic [7:0]  status_q;
  logic [7:0]  status_clr;
  logic [63:0] cycle_cnt;
  logic [31:0] cycle_hi_snap;
  logic        unused_bits;

  // Readys are combinational so they drop during reset and rise on the very first cycle after it
  assign S_AXI.awready = ~reset_rtl_0 & ~aw_held & ~S_AXI.bvalid;
  assign S_AXI.wready  = ~reset_rtl_0 & ~w_held  & ~S_AXI.bvalid;
  assign S_AXI.arready = ~reset_rtl_0 & ~S_AXI.rvalid;

  assign aw_hs    = S_AXI.awvalid & S_AXI.awready;
  assign w_hs     = S_AXI.wvalid  & S_AXI.wready;
  assign ar_hs    = S_AXI.arvalid & S_AXI.arready;
  assign ar_idx   = S_AXI.araddr[11:2];
  assign do_write = aw_held & w_held;
  assign wr_resp  = (aw_idx <= IDX_CYCLE_HI) ? RESP_OKAY : RESP_SLVERR;

  assign status_clr = (do_write && aw_idx == IDX_STATUS && w_strb[0]) ? w_data[7:0] : 8'h00;
  assign ctrl_out   = ctrl_q;

  // Only the word index selects a register; protection and the rest of the address are don't-care
  assign unused_bits = ^{S_AXI.awprot, S_AXI.arprot,
                         S_AXI.awaddr[31:12], S_AXI.awaddr[1:0],
                         S_AXI.araddr[31:12], S_AXI.araddr[1:0]};

  // Write channel: hold AW and W independently, commit and respond once both are present
  always_ff @(posedge Clk or posedge reset_rtl_0) begin
    if (reset_rtl_0) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI.bvalid <= 1'b0;
      S_AXI.bresp  <= RESP_OKAY;
    end else begin
      if (S_AXI.bvalid && S_AXI.bready) begin
        S_AXI.bvalid <= 1'b0;
      end
      if (do_write) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI.bvalid <= 1'b1;
        S_AXI.bresp  <= wr_resp;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_idx  <= S_AXI.awaddr[11:2];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= S_AXI.wdata;
          w_strb <= S_AXI.wstrb;
        end
      end
    end
  end

  // SCRATCH and CTRL updates with byte enables
  always_ff @(posedge Clk or posedge reset_rtl_0) begin
    if (reset_rtl_0) begin
      scratch_q <= '0;
      ctrl_q    <= '0;
    end else if (do_write) begin
      if (aw_idx == IDX_SCRATCH) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b]) scratch_q[8*b +: 8] <= w_data[8*b +: 8];
        end
      end
      if (aw_idx == IDX_CTRL && w_strb[0]) begin
        ctrl_q <= w_data[7:0];
      end
    end
  end

  // STATUS: sticky set from status_in, write-one-to-clear; a coincident set beats the clear
  always_ff @(posedge Clk or posedge reset_rtl_0) begin
    if (reset_rtl_0) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~status_clr) | status_in;
    end
  end

  // Free-running 64-bit cycle counter
  always_ff @(posedge Clk or posedge reset_rtl_0) begin
    if (reset_rtl_0) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
    end
  end

  // Reading CYCLE_LO freezes the upper half so a following CYCLE_HI read forms a coherent pair
  always_ff @(posedge Clk or posedge reset_rtl_0) begin
    if (reset_rtl_0) begin
      cycle_hi_snap <= '0;
    end else if (ar_hs && ar_idx == IDX_CYCLE_LO) begin
      cycle_hi_snap <= cycle_cnt[63:32];
    end
  end

  // Read decode of the current register contents
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ar_idx)
      IDX_ID:       rd_data = ID_VALUE;
      IDX_SCRATCH:  rd_data = scratch_q;
      IDX_CTRL:     rd_data = {24'h0, ctrl_q};
      IDX_STATUS:   rd_data = {24'h0, status_q};
      IDX_CYCLE_LO: rd_data = cycle_cnt[31:0];
      IDX_CYCLE_HI: rd_data = cycle_hi_snap;
      default:      rd_resp = RESP_SLVERR;
    endcase
  end

  // Read channel: register the response on AR handshake, hold it until accepted
  always_ff @(posedge Clk or posedge reset_rtl_0) begin
    if (reset_rtl_0) begin
      S_AXI.rvalid <= 1'b0;
      S_AXI.rdata  <= '0;
      S_AXI.rresp  <= RESP_OKAY;
    end else begin
      if (S_AXI.rvalid && S_AXI.rready) begin
        S_AXI.rvalid <= 1'b0;
      end
      if (ar_hs) begin
        S_AXI.rvalid <= 1'b1;
        S_AXI.rdata  <= rd_data;
        S_AXI.rresp  <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// tb/tb_axil_regbank.sv - randomized scoreboard bench for the AXI4-Lite register bank

module tb_axil_regbank;

  localparam logic [31:0] ID = 32'h4B32_5D01;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  status_in;
  logic [7:0]  ctrl_out;
  logic [63:0] cyc = 64'd0;

  axil_regbank_if bus();

  axil_regbank #(.ID_VALUE(ID)) dut (
    .Clk(clk),
    .reset_rtl_0(rst),
    .S_AXI(bus),
    .ctrl_out(ctrl_out),
    .status_in(status_in)
  );

  always #5 clk = ~clk;

  // free-running edge count used to derive the expected counter value
  always @(posedge clk) cyc <= cyc + 64'd1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  logic [31:0] m_scratch;
  logic [7:0]  m_ctrl;
  logic [7:0]  m_status;
  logic [31:0] m_snap;
  logic [63:0] cnt_org_val;
  logic [63:0] cnt_org_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no handshake expected handshake within bound (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_scratch   = '0;
    m_ctrl      = '0;
    m_status    = '0;
    m_snap      = '0;
    cnt_org_val = '0;
    cnt_org_cyc = cyc;
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [33:0] e);
    logic [63:0] c;
    logic [9:0]  idx;
    c   = cnt_org_val + (cyc - cnt_org_cyc);
    idx = addr[11:2];
    case (idx)
      10'd0: e = {2'b00, ID};
      10'd1: e = {2'b00, m_scratch};
      10'd2: e = {2'b00, 24'h0, m_ctrl};
      10'd3: e = {2'b00, 24'h0, m_status};
      10'd4: begin e = {2'b00, c[31:0]}; m_snap = c[63:32]; end
      10'd5: e = {2'b00, m_snap};
      default: e = {2'b10, 32'h0};
    endcase
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [7:0] sin, output logic [1:0] resp);
    logic [9:0] idx;
    idx  = addr[11:2];
    resp = 2'b00;
    case (idx)
      10'd0, 10'd4, 10'd5: ;
      10'd1: for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
      10'd2: if (strb[0]) m_ctrl = data[7:0];
      10'd3: if (strb[0]) m_status = m_status & ~data[7:0];
      default: resp = 2'b10;
    endcase
    m_status = m_status | sin;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input logic [7:0] sin);
    bit aw_done, w_done, aw_hs, w_hs;
    int t;
    logic [1:0] resp;
    aw_done = 0; w_done = 0; t = 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!(aw_done && w_done)) begin
      bus.awvalid = !aw_done && t >= aw_dly;
      bus.wvalid  = !w_done && t >= w_dly;
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      t++;
      if (t > 40) begin timeout("aw_w_accept"); break; end
    end
    bus.awvalid = 0;
    bus.wvalid  = 0;
    chk("bvalid_early", bus.bvalid, 0);
    status_in = sin;
    tick();
    status_in = 0;
    model_write(addr, data, strb, sin, resp);
    bq.push_back(resp);
    chk("bvalid_latency", bus.bvalid, 1);
    chk("ctrl_out", ctrl_out, m_ctrl);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      chk("bvalid_hold", bus.bvalid, 1);
      chk("awready_during_b", bus.awready, 0);
    end
    bus.bready = 1;
    tick();
    bus.bready = 0;
    chk("bvalid_clear", bus.bvalid, 0);
    chk("awready_after_b", bus.awready, 1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly, input bit accept);
    int t;
    logic [33:0] e;
    t = 0;
    bus.araddr  = addr;
    bus.arvalid = 1;
    while (!bus.arready) begin
      tick();
      t++;
      if (t > 40) begin timeout("ar_accept"); break; end
    end
    model_read(addr, e);
    if (accept) rq.push_back(e);
    tick();
    bus.arvalid = 0;
    chk("rvalid_latency", bus.rvalid, 1);
    chk("arready_busy", bus.arready, 0);
    if (accept) begin
      for (int i = 0; i < r_dly; i++) begin
        tick();
        chk("rvalid_hold", bus.rvalid, 1);
      end
      bus.rready = 1;
      tick();
      bus.rready = 0;
      chk("rvalid_clear", bus.rvalid, 0);
      chk("arready_after_r", bus.arready, 1);
    end
  endtask

  task automatic pulse_status(input logic [7:0] v);
    status_in = v;
    tick();
    status_in = 0;
    m_status = m_status | v;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, bus.awready, 0);
    chk({tag, "_wready"}, bus.wready, 0);
    chk({tag, "_arready"}, bus.arready, 0);
    chk({tag, "_bvalid"}, bus.bvalid, 0);
    chk({tag, "_rvalid"}, bus.rvalid, 0);
    chk({tag, "_rdata_rresp_bresp"}, {bus.rdata, bus.rresp, bus.bresp}, 0);
    chk({tag, "_ctrl_out"}, ctrl_out, 0);
  endtask

  task automatic release_reset();
    tick();
    tick();
    rst = 0;
    model_clear();
    #1;
    chk("post_rst_awready", bus.awready, 1);
    chk("post_rst_wready", bus.wready, 1);
    chk("post_rst_arready", bus.arready, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    logic [9:0]  idx;
    int k;
    r = $urandom();
    k = $urandom_range(0, 9);
    if (k <= 7)      idx = 10'(k);
    else if (k == 8) idx = 10'($urandom_range(6, 1023));
    else             idx = 10'h040;
    return {r[31:12], idx, r[1:0]};
  endfunction

  initial begin
    logic [33:0] e;
    logic [1:0]  eb;
    logic [31:0] a;

    fork
      // scoreboard monitor: pop and compare whenever a response is accepted
      forever begin
        @(negedge clk);
        if (bus.rvalid && bus.rready) begin
          if (rq.size() == 0) timeout("r_unexpected");
          else begin
            e = rq.pop_front();
            chk("rdata", bus.rdata, e[31:0]);
            chk("rresp", bus.rresp, e[33:32]);
          end
        end
        if (bus.bvalid && bus.bready) begin
          if (bq.size() == 0) timeout("b_unexpected");
          else begin
            eb = bq.pop_front();
            chk("bresp", bus.bresp, eb);
          end
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
      end
    join_none

    rst = 1;
    status_in = 0;
    bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0;
    bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
    #2;
    check_reset_outputs("rst");
    release_reset();

    // directed: same-cycle AW/W then read back
    axi_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 8'h00);
    axi_read(32'h4, 0, 1);
    // directed: W three cycles ahead of AW, slow bready
    axi_write(32'h8, 32'h0000_01A5, 4'h1, 3, 0, 4, 8'h00);
    axi_read(32'h8, 1, 1);
    // directed: status set / clear / set-wins
    pulse_status(8'h81);
    axi_read(32'hC, 0, 1);
    axi_write(32'hC, 32'h01, 4'h1, 0, 0, 0, 8'h00);
    axi_read(32'hC, 0, 1);
    axi_write(32'hC, 32'h80, 4'h1, 0, 1, 0, 8'h80);
    axi_read(32'hC, 0, 1);
    // directed: unmapped and ID
    axi_read(32'h18, 0, 1);
    axi_write(32'h100, 32'h1234_5678, 4'hF, 1, 0, 0, 8'h00);
    axi_read(32'h0, 0, 1);
    // directed: concurrent read and write
    fork
      axi_write(32'h4, 32'h0BAD_F00D, 4'h5, 0, 2, 1, 8'h00);
      axi_read(32'hFFFF_F000, 2, 1);
    join
    axi_read(32'h4, 0, 1);
    // directed: counter pair near wrap
    force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    release dut.cycle_cnt;
    cnt_org_val = 64'hFFFF_FFFF_FFFF_FFFE;
    cnt_org_cyc = cyc;
    axi_read(32'h10, 0, 1);
    axi_read(32'h14, 0, 1);
    axi_read(32'h10, 0, 1);
    axi_read(32'h14, 0, 1);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      bus.awprot = 3'($urandom_range(0, 7));
      bus.arprot = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0, 1: axi_write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                        ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00);
        2, 3: axi_read(rand_addr(), $urandom_range(0, 2), 1);
        default: pulse_status(8'($urandom()));
      endcase
    end

    // reset in the middle of a pending read response and a held write address
    axi_read(32'h4, 0, 0);
    a = 32'h8;
    bus.awaddr = a;
    bus.awvalid = 1;
    tick();
    bus.awvalid = 0;
    chk("aw_held_blocks", bus.awready, 0);
    rst = 1;
    #1;
    check_reset_outputs("mid_rst");
    release_reset();
    axi_read(32'h4, 0, 1);
    axi_read(32'hC, 0, 1);
    axi_read(32'h10, 0, 1);
    tick();
    tick();

    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
